// File: rtl/popcount_weighted_accumulator.sv
// Frame-based weighted popcount accumulator: word k of each PHASES-word frame adds popcount<<k.
// Two-stage pipeline, result on valid/ready with sticky overflow; input stalls while a result is pending.
module popcount_weighted_accumulator #(
  parameter int DATA_W = 16,
  parameter int PHASES = 4,
  parameter int ACC_W  = 8,
  parameter int SAT_EN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_result,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int PC_W   = $clog2(DATA_W + 1);
  localparam int PH_W   = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam int TERM_W = PC_W + PHASES - 1;
  localparam int SUM_W  = ((ACC_W > TERM_W) ? ACC_W : TERM_W) + 1;

  localparam logic [PH_W-1:0]  LAST_PH = PH_W'(PHASES - 1);
  localparam logic [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};

  typedef enum logic [1:0] {ACCUM, CLOSED, OUTPUT} state_t;

  state_t            state;
  logic [PH_W-1:0]   phase;
  logic [ACC_W-1:0]  acc;
  logic              ovf;

  logic              a_valid;
  logic [DATA_W-1:0] a_data;
  logic [PH_W-1:0]   a_phase;
  logic              a_last;

  logic [TERM_W-1:0] term;
  logic [SUM_W-1:0]  sum;
  logic              ovf_step;
  logic [ACC_W-1:0]  acc_next;
  logic              take;

  function automatic logic [PC_W-1:0] popcount(input logic [DATA_W-1:0] w);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) c = c + PC_W'(w[i]);
    return c;
  endfunction

  assign take = in_valid && in_ready;

  // Full-precision sum so a single oversized term is caught even with acc==0.
  always_comb begin
    term     = TERM_W'(popcount(a_data)) << a_phase;
    sum      = SUM_W'(acc) + SUM_W'(term);
    ovf_step = (sum > ACC_MAX);
    if (ovf_step && (SAT_EN != 0)) acc_next = '1;
    else                           acc_next = sum[ACC_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACCUM;
      phase      <= '0;
      acc        <= '0;
      ovf        <= 1'b0;
      a_valid    <= 1'b0;
      a_data     <= '0;
      a_phase    <= '0;
      a_last     <= 1'b0;
      in_ready   <= 1'b1;
      out_result <= '0;
      out_ovf    <= 1'b0;
      out_valid  <= 1'b0;
    end else if (clear) begin
      state     <= ACCUM;
      phase     <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      a_valid   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      // Stage A: capture the word with its position in the frame.
      a_valid <= take;
      if (take) begin
        a_data  <= in_data;
        a_phase <= phase;
        a_last  <= (phase == LAST_PH);
        phase   <= (phase == LAST_PH) ? '0 : phase + PH_W'(1);
      end

      // Stage B: accumulate; the last word publishes and clears for the next frame.
      if (a_valid) begin
        if (a_last) begin
          out_result <= acc_next;
          out_ovf    <= ovf | ovf_step;
          acc        <= '0;
          ovf        <= 1'b0;
        end else begin
          acc <= acc_next;
          ovf <= ovf | ovf_step;
        end
      end

      case (state)
        ACCUM: begin
          if (take && (phase == LAST_PH)) begin
            in_ready <= 1'b0;
            state    <= CLOSED;
          end
        end
        CLOSED: begin
          if (a_valid && a_last) begin
            out_valid <= 1'b1;
            state     <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_weighted_accumulator.sv
// Bench for popcount_weighted_accumulator: three variants (8-bit wrap, 7-bit saturate, 7-bit wrap) share stimulus.
module tb_popcount_weighted_accumulator;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, out_ready;
  logic [15:0] in_data;

  logic       ir8, ir7s, ir7w;
  logic [7:0] r8;
  logic [6:0] r7s, r7w;
  logic       o8, o7s, o7w;
  logic       v8, v7s, v7w;

  logic [8:0] q8[$];
  logic [8:0] q7s[$];
  logic [8:0] q7w[$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  popcount_weighted_accumulator #(.DATA_W(16), .PHASES(4), .ACC_W(8), .SAT_EN(0)) u_d8 (
    .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir8), .out_result(r8), .out_ovf(o8), .out_valid(v8), .out_ready(out_ready));

  popcount_weighted_accumulator #(.DATA_W(16), .PHASES(4), .ACC_W(7), .SAT_EN(1)) u_d7s (
    .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir7s), .out_result(r7s), .out_ovf(o7s), .out_valid(v7s), .out_ready(out_ready));

  popcount_weighted_accumulator #(.DATA_W(16), .PHASES(4), .ACC_W(7), .SAT_EN(0)) u_d7w (
    .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir7w), .out_result(r7w), .out_ovf(o7w), .out_valid(v7w), .out_ready(out_ready));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected {ovf, result}: overflow iff the exact frame sum exceeds the width.
  function automatic logic [8:0] model(input int total, input int w, input bit sat);
    int mx;
    mx = (1 << w) - 1;
    if (total > mx) return {1'b1, sat ? 8'(mx) : 8'(total & mx)};
    return {1'b0, 8'(total)};
  endfunction

  always @(negedge clk) begin
    if (!rst && !clear && v8 && out_ready) begin
      if (q8.size() == 0) check("d8_unexpected", 1, 0);
      else check("d8_result", {o8, r8}, q8.pop_front());
    end
    if (!rst && !clear && v7s && out_ready) begin
      if (q7s.size() == 0) check("d7s_unexpected", 1, 0);
      else check("d7s_result", {o7s, 1'b0, r7s}, q7s.pop_front());
    end
    if (!rst && !clear && v7w && out_ready) begin
      if (q7w.size() == 0) check("d7w_unexpected", 1, 0);
      else check("d7w_result", {o7w, 1'b0, r7w}, q7w.pop_front());
    end
  end

  task automatic send_word(input logic [15:0] d);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (ir8) break;
      n++;
      if (n > 200) begin
        check("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] w0, w1, w2, w3, input int gap);
    logic [15:0] w[4];
    int total;
    w = '{w0, w1, w2, w3};
    total = 0;
    for (int k = 0; k < 4; k++) begin
      total += $countones(w[k]) << k;
      send_word(w[k]);
      if (k < 3) repeat (gap) begin @(posedge clk); #1; end
    end
    q8.push_back(model(total, 8, 1'b0));
    q7s.push_back(model(total, 7, 1'b1));
    q7w.push_back(model(total, 7, 1'b0));
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!v8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!v8) check("out_valid_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", v8, 0);
    check("rst_in_ready", ir8, 1);
    check("rst_out_result", r8, 0);
    check("rst_out_ovf", o8, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full words back-to-back, with exact output latency.
    send_frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0);
    @(negedge clk);
    check("lat_valid_early", v8, 0);
    check("lat_in_ready_low", ir8, 0);
    @(negedge clk);
    check("lat_valid_2clk", v8, 1);

    // Growing patterns with idle gaps mid-frame.
    send_frame(16'h0001, 16'h0003, 16'h0007, 16'h000F, 1);
    // Overflow must not leak into the following frame.
    send_frame(16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);

    // Back-pressure: result held, input stalled.
    send_frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0);
    out_ready = 1'b0;
    wait_valid();
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_result", r8, 240);
      check("bp_hold_valid", v8, 1);
      check("bp_in_ready", ir8, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_frame(16'h0001, 16'h0001, 16'h0001, 16'h0001, 0);

    // clear while a result waits: it is discarded.
    send_frame(16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
    out_ready = 1'b0;
    wait_valid();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_out_valid", v8, 0);
    check("clr_in_ready", ir8, 1);
    void'(q8.pop_back());
    void'(q7s.pop_back());
    void'(q7w.pop_back());
    out_ready = 1'b1;

    // clear mid-frame, with a word offered in the clear cycle.
    send_word(16'hFFFF);
    send_word(16'hFFFF);
    clear = 1'b1; in_valid = 1'b1; in_data = 16'hFFFF;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    send_frame(16'h0001, 16'h0001, 16'h0001, 16'h0001, 0);
    repeat (4) begin @(posedge clk); #1; end
    check("pre_rst_result", r8, 15);

    // Async reset mid-frame, no clock edge needed.
    send_word(16'hFFFF);
    send_word(16'hFFFF);
    send_word(16'hFFFF);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_result", r8, 0);
    check("arst_in_ready", ir8, 1);
    check("arst_out_valid", v8, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0);

    repeat (8) begin @(posedge clk); #1; end
    check("q8_drained", q8.size(), 0);
    check("q7s_drained", q7s.size(), 0);
    check("q7w_drained", q7w.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
